// File: rtl/lcd_text_writer.sv
// ---------------------------------------------------------------------------
// lcd_text_writer
//
// Character-stream front end for an HD44780-style LCD controller. Printable
// bytes arrive on a valid/ready port and are queued in a small FIFO. A cursor
// is tracked over a 2-line display, and the matching DDRAM-address and
// data-write transactions are issued to the controller. The controller's
// `busy` signal is the only flow control back into this block.
//
// Parameters:
//   FIFO_DEPTH  character FIFO entries (power of 2, >= 2)
//   COLS        visible columns per display line (1..40)
//
// Ports:
//   clk         single clock, rising edge
//   reset_n     asynchronous active-low reset
//   char_valid  char_data holds a byte to display
//   char_data   character code
//   char_ready  byte accepted when char_valid && char_ready at a rising edge
//   clear_req   single-cycle request to clear the display and home the cursor
//   busy        controller busy, from the LCD controller
//   lcd_enable  transaction request to the controller
//   lcd_bus     {rs, rw, data[7:0]} to the controller
//   fifo_count  current FIFO occupancy
// ---------------------------------------------------------------------------
module lcd_text_writer #(
    parameter int FIFO_DEPTH = 16,
    parameter int COLS       = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          char_valid,
    input  logic [7:0]                    char_data,
    output logic                          char_ready,
    input  logic                          clear_req,
    input  logic                          busy,
    output logic                          lcd_enable,
    output logic [9:0]                    lcd_bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [CNTW-1:0] DEPTH_COUNT = CNTW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   LAST_COL    = CW'(COLS - 1);

    // Command word for "clear display" (rs=0, rw=0, data=8'h01).
    localparam logic [9:0] CMD_CLEAR = 10'h001;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_CLEAR,
        ISSUE_ADDR,
        ISSUE_DATA,
        WAIT_DONE
    } state_t;

    // -----------------------------------------------------------------------
    // Storage and state
    // -----------------------------------------------------------------------
    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    state_t         state;
    state_t         state_next;
    logic           enable_next;
    logic [9:0]     bus_next;

    logic           cursor_line;
    logic           line_next;
    logic [CW-1:0]  cursor_col;
    logic [CW-1:0]  col_next;
    logic           need_addr;
    logic           need_addr_next;
    logic           clear_pending;
    logic           clear_pending_next;

    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic [7:0]     fifo_head;
    logic [9:0]     addr_word;

    assign fifo_full  = (fifo_count == DEPTH_COUNT);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_head  = fifo_mem[rd_ptr];

    // Ready is purely combinational so it is already high while in reset.
    // A clear request blocks the byte offered in the same cycle because the
    // FIFO is being flushed on that edge.
    assign char_ready = !fifo_full && !clear_pending && !clear_req;
    assign push       = char_valid && char_ready;

    // Set-DDRAM-address command: line 1 starts at DDRAM 0x40.
    assign addr_word = {3'b001, cursor_line ? (7'h40 + 7'(cursor_col)) : 7'(cursor_col)};

    // -----------------------------------------------------------------------
    // FIFO storage; no reset needed, validity is tracked by the pointers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= char_data;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and occupancy. A clear request flushes everything and
    // takes priority over a pop from a DATA transaction completing on the
    // same edge. Push and pop together leave the count unchanged.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (clear_req) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNTW'(1);
                2'b01:   fifo_count <= fifo_count - CNTW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM state register, registered bus outputs and cursor bookkeeping.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            lcd_enable    <= 1'b0;
            lcd_bus       <= '0;
            cursor_line   <= 1'b0;
            cursor_col    <= '0;
            need_addr     <= 1'b1;
            clear_pending <= 1'b0;
        end else begin
            state         <= state_next;
            lcd_enable    <= enable_next;
            lcd_bus       <= bus_next;
            cursor_line   <= line_next;
            cursor_col    <= col_next;
            need_addr     <= need_addr_next;
            clear_pending <= clear_pending_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic.
    // A job is only started from IDLE when the controller is not busy, so a
    // controller that is still initialising never sees lcd_enable. Each
    // ISSUE state holds enable and the bus word until busy is sampled high,
    // then commits the job's side effects and drops the bus.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next         = state;
        enable_next        = lcd_enable;
        bus_next           = lcd_bus;
        line_next          = cursor_line;
        col_next           = cursor_col;
        need_addr_next     = need_addr;
        clear_pending_next = clear_pending || clear_req;
        pop                = 1'b0;

        case (state)
            IDLE: begin
                if (!busy) begin
                    if (clear_pending) begin
                        state_next  = ISSUE_CLEAR;
                        enable_next = 1'b1;
                        bus_next    = CMD_CLEAR;
                    end else if (!fifo_empty && need_addr) begin
                        state_next  = ISSUE_ADDR;
                        enable_next = 1'b1;
                        bus_next    = addr_word;
                    end else if (!fifo_empty) begin
                        state_next  = ISSUE_DATA;
                        enable_next = 1'b1;
                        bus_next    = {2'b10, fifo_head};
                    end
                end
            end

            ISSUE_CLEAR: begin
                if (busy) begin
                    state_next         = WAIT_DONE;
                    enable_next        = 1'b0;
                    bus_next           = '0;
                    line_next          = 1'b0;
                    col_next           = '0;
                    need_addr_next     = 1'b1;
                    // A fresh request arriving on the completion edge survives.
                    clear_pending_next = clear_req;
                end
            end

            ISSUE_ADDR: begin
                if (busy) begin
                    state_next     = WAIT_DONE;
                    enable_next    = 1'b0;
                    bus_next       = '0;
                    need_addr_next = 1'b0;
                end
            end

            ISSUE_DATA: begin
                if (busy) begin
                    state_next  = WAIT_DONE;
                    enable_next = 1'b0;
                    bus_next    = '0;
                    // The FIFO may already have been flushed by a clear while
                    // this word was in flight; never pop an empty FIFO.
                    pop         = !fifo_empty;
                    if (cursor_col == LAST_COL) begin
                        col_next       = '0;
                        line_next      = !cursor_line;
                        need_addr_next = 1'b1;
                    end else begin
                        col_next = cursor_col + CW'(1);
                    end
                end
            end

            WAIT_DONE: begin
                if (!busy) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next  = IDLE;
                enable_next = 1'b0;
                bus_next    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_text_writer.sv
// ---------------------------------------------------------------------------
// tb_lcd_text_writer
//
// Self-checking bench for lcd_text_writer. A small controller model raises
// busy one cycle after it samples lcd_enable, holds it for a random number of
// cycles and records every accepted bus word. Expected word streams come from
// a table of hand-derived vectors, hand-written corner sequences, and a
// cursor model that turns the list of accepted characters into bus words.
// ---------------------------------------------------------------------------
module tb_lcd_text_writer;

    localparam int FIFO_DEPTH = 16;
    localparam int COLS       = 16;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data  = 8'h00;
    logic        clear_req  = 1'b0;
    logic        busy       = 1'b0;
    logic        char_ready;
    logic        lcd_enable;
    logic [9:0]  lcd_bus;
    logic [4:0]  fifo_count;

    always #5 clk = ~clk;

    lcd_text_writer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .COLS       (COLS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .busy       (busy),
        .lcd_enable (lcd_enable),
        .lcd_bus    (lcd_bus),
        .fifo_count (fifo_count)
    );

    int testsRun  = 0;
    int failCount = 0;

    // Controller model state
    bit          holdBusy = 1'b0;
    int          busyMin  = 1;
    int          busyMax  = 4;
    int          busyCnt  = 0;
    bit          seen     = 1'b0;
    logic [9:0]  firstBus = '0;
    int          enRun    = 0;
    int          runErr   = 0;
    int          stabErr  = 0;

    logic [9:0]  obsQ[$];
    logic [9:0]  expQ[$];

    // Cursor reference model
    int          modelLine;
    int          modelCol;
    bit          modelNeedAddr;

    typedef struct {
        logic [7:0] ch;
        int         nWords;
        logic [9:0] exp0;
        logic [9:0] exp1;
    } vec_t;

    // Controller model: acts on the falling edge so busy is stable around the
    // DUT's rising edge. It samples enable, raises busy one cycle later and
    // records the word, then holds busy for a random number of cycles.
    always @(negedge clk) begin
        if (lcd_enable) enRun++;
        else            enRun = 0;
        if (enRun > 2) runErr++;

        if (!reset_n) begin
            busy    = holdBusy;
            busyCnt = 0;
            seen    = 1'b0;
        end else if (holdBusy) begin
            busy = 1'b1;
            seen = 1'b0;
        end else if (busyCnt > 0) begin
            busyCnt--;
            if (busyCnt == 0) busy = 1'b0;
        end else begin
            busy = 1'b0;
            if (!lcd_enable) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen     = 1'b1;
                firstBus = lcd_bus;
            end else begin
                if (lcd_bus !== firstBus) stabErr++;
                obsQ.push_back(lcd_bus);
                busy    = 1'b1;
                busyCnt = int'($urandom_range(busyMax, busyMin));
                seen    = 1'b0;
            end
        end
    end

    function automatic void modelReset();
        modelLine     = 0;
        modelCol      = 0;
        modelNeedAddr = 1'b1;
    endfunction

    // Each character costs an address command first whenever the cursor has
    // just been homed or wrapped to column 0.
    function automatic void modelChar(input logic [7:0] ch);
        if (modelNeedAddr) begin
            expQ.push_back(10'(128 + modelLine * 64 + modelCol));
            modelNeedAddr = 1'b0;
        end
        expQ.push_back(10'(512 + int'(ch)));
        modelCol++;
        if (modelCol == COLS) begin
            modelCol      = 0;
            modelLine     = 1 - modelLine;
            modelNeedAddr = 1'b1;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit valid, input logic [7:0] data, input bit clr, output bit accepted);
        @(negedge clk);
        char_valid = valid;
        char_data  = data;
        clear_req  = clr;
        #1;
        accepted = valid && char_ready;
    endtask

    task automatic pushChar(input logic [7:0] d, input bit useModel);
        bit acc;
        bit dummy;
        acc = 1'b0;
        for (int i = 0; i < 2000 && !acc; i++) begin
            applyStimulus(1'b1, d, 1'b0, acc);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, dummy);
        if (!acc) checkOutput("push timeout", 32'd0, 32'd1);
        else if (useModel) modelChar(d);
    endtask

    task automatic waitQuiet(input int maxCycles);
        int quiet;
        bit done;
        quiet = 0;
        done  = 1'b0;
        for (int i = 0; i < maxCycles && !done; i++) begin
            @(negedge clk);
            #2;
            if (fifo_count == 0 && !lcd_enable && !busy) quiet++;
            else quiet = 0;
            if (quiet >= 6) done = 1'b1;
        end
        if (!done) checkOutput("drain timeout", 32'd0, 32'd1);
    endtask

    task automatic checkStream(input string tag);
        checkOutput($sformatf("%s word count", tag), obsQ.size(), expQ.size());
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            checkOutput($sformatf("%s word %0d", tag, i), 32'(obsQ[i]), 32'(expQ[i]));
        end
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic doReset(input bit hold);
        holdBusy = hold;
        @(negedge clk);
        reset_n    = 1'b0;
        char_valid = 1'b0;
        clear_req  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        obsQ.delete();
        expQ.delete();
        modelReset();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[5];
        bit          acc;
        bit          found;
        bit          v;
        int          bad;
        int          accCount;
        logic [7:0]  d;

        vecs[0] = '{8'h41, 2, 10'h080, 10'h241};
        vecs[1] = '{8'h42, 1, 10'h242, 10'h000};
        vecs[2] = '{8'h7E, 1, 10'h27E, 10'h000};
        vecs[3] = '{8'h20, 1, 10'h220, 10'h000};
        vecs[4] = '{8'h00, 1, 10'h200, 10'h000};

        // Reset held, then released with the controller still busy.
        holdBusy = 1'b1;
        reset_n  = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("ready in reset", 32'(char_ready), 32'd1);
        checkOutput("enable in reset", 32'(lcd_enable), 32'd0);
        checkOutput("bus in reset", 32'(lcd_bus), 32'd0);
        checkOutput("count in reset", 32'(fifo_count), 32'd0);
        reset_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            #1;
            if (lcd_enable !== 1'b0 || lcd_bus !== 10'h000 || char_ready !== 1'b1 || fifo_count !== 5'd0) bad++;
        end
        checkOutput("busy idle bad cycles", 32'(bad), 32'd0);
        holdBusy = 1'b0;
        repeat (3) @(negedge clk);

        // Table-driven single characters from a freshly reset cursor.
        doReset(1'b0);
        for (int i = 0; i < 5; i++) begin
            pushChar(vecs[i].ch, 1'b0);
            waitQuiet(500);
            expQ.push_back(vecs[i].exp0);
            if (vecs[i].nWords == 2) expQ.push_back(vecs[i].exp1);
            checkStream($sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d count", i), 32'(fifo_count), 32'd0);
        end

        // Line wrap: 17 characters, then 32 more to wrap back to line 0.
        doReset(1'b0);
        for (int i = 0; i < 17; i++) pushChar(8'(8'h30 + i), 1'b1);
        waitQuiet(3000);
        checkOutput("wrap size", obsQ.size(), 32'd19);
        if (obsQ.size() >= 19) begin
            checkOutput("wrap first addr", 32'(obsQ[0]), 32'h080);
            checkOutput("wrap line1 addr", 32'(obsQ[17]), 32'h0C0);
            checkOutput("wrap line1 data", 32'(obsQ[18]), 32'h240);
        end
        checkStream("wrap a");
        for (int i = 0; i < 32; i++) pushChar(8'(8'h41 + i), 1'b1);
        waitQuiet(5000);
        if (obsQ.size() >= 34) begin
            checkOutput("wrap home addr", 32'(obsQ[15]), 32'h080);
            checkOutput("wrap second line1", 32'(obsQ[32]), 32'h0C0);
        end
        checkStream("wrap b");

        // FIFO full while the controller is stuck busy.
        doReset(1'b1);
        for (int i = 0; i < 16; i++) pushChar(8'(8'h50 + i), 1'b1);
        @(negedge clk);
        #1;
        checkOutput("full count", 32'(fifo_count), 32'd16);
        checkOutput("full ready", 32'(char_ready), 32'd0);
        accCount = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'h99, 1'b0, acc);
            if (acc) accCount++;
        end
        applyStimulus(1'b0, 8'h00, 1'b0, acc);
        checkOutput("17th rejected", 32'(accCount), 32'd0);
        checkOutput("full count held", 32'(fifo_count), 32'd16);
        holdBusy = 1'b0;
        waitQuiet(3000);
        checkStream("full");

        // Clear while a DATA word is in flight, with a byte offered alongside.
        doReset(1'b0);
        busyMin = 20;
        busyMax = 20;
        for (int i = 0; i < 6; i++) pushChar(8'(8'h30 + i), 1'b0);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            #1;
            if (lcd_enable && lcd_bus[9]) found = 1'b1;
        end
        checkOutput("data in flight", 32'(found), 32'd1);
        char_valid = 1'b1;
        char_data  = 8'h55;
        clear_req  = 1'b1;
        #1;
        checkOutput("ready during clear", 32'(char_ready), 32'd0);
        @(negedge clk);
        char_valid = 1'b0;
        clear_req  = 1'b0;
        #1;
        checkOutput("flushed count", 32'(fifo_count), 32'd0);
        busyMin = 1;
        busyMax = 4;
        waitQuiet(2000);
        expQ.push_back(10'h080);
        expQ.push_back(10'h230);
        expQ.push_back(10'h001);
        checkStream("clear");
        pushChar(8'h5A, 1'b0);
        waitQuiet(500);
        expQ.push_back(10'h080);
        expQ.push_back(10'h25A);
        checkStream("after clear");

        // Asynchronous reset while a transaction is being issued.
        pushChar(8'h41, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            #1;
            if (lcd_enable) found = 1'b1;
        end
        checkOutput("enable seen", 32'(found), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async enable", 32'(lcd_enable), 32'd0);
        checkOutput("async bus", 32'(lcd_bus), 32'd0);
        checkOutput("async count", 32'(fifo_count), 32'd0);
        checkOutput("async ready", 32'(char_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        obsQ.delete();
        expQ.delete();
        modelReset();
        repeat (3) @(negedge clk);
        pushChar(8'h42, 1'b0);
        waitQuiet(500);
        expQ.push_back(10'h080);
        expQ.push_back(10'h242);
        checkStream("post reset");

        // Randomised traffic against the cursor model.
        doReset(1'b0);
        busyMin = 1;
        busyMax = 5;
        for (int i = 0; i < 300; i++) begin
            v = 1'($urandom_range(1, 0));
            d = 8'($urandom_range(32'h7E, 32'h20));
            applyStimulus(v, d, 1'b0, acc);
            checkOutput("ready rule", 32'(char_ready), 32'(fifo_count != 5'd16));
            if (acc) modelChar(d);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, acc);
        waitQuiet(8000);
        checkStream("random");

        checkOutput("enable run length", 32'(runErr), 32'd0);
        checkOutput("bus stable while enabled", 32'(stabErr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/lcd_text_writer.md
# lcd_text_writer

Character-stream front end for the HD44780-style LCD controller. Accepts printable bytes through a valid/ready port, buffers them in a small FIFO, tracks the cursor over a 2-line display and issues the matching DDRAM-address and data-write transactions to the controller's `lcd_enable`/`lcd_bus`/`busy` port. Sits directly upstream of the LCD controller; the controller's `busy` is the only flow-control signal back.

## Interface

- `FIFO_DEPTH`, 16: character FIFO entries, power of 2, ≥2.
- `COLS`, 16: visible columns per line, 1..40.
- `clk` input 1: single clock, all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `char_valid` input 1: `char_data` holds a byte to display.
- `char_data` input 8: character code.
- `char_ready` output 1: byte accepted when `char_valid && char_ready` at a rising edge.
- `clear_req` input 1: single-cycle request to clear display and home cursor.
- `busy` input 1: controller busy, from the LCD controller.
- `lcd_enable` output 1: transaction request to the controller.
- `lcd_bus` output 10: {rs, rw, data[7:0]} to the controller.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation

- Reset (async assert): FIFO emptied, `fifo_count`=0, `lcd_enable`=0, `lcd_bus`=0, cursor line=0 col=0, `need_addr`=1, `clear_pending`=0, FSM=IDLE. `char_ready` is combinational, so it is 1 during and after reset.
- `char_ready` = !full && !clear_pending && !clear_req. Push on `char_valid && char_ready`.
- `clear_req`: sets `clear_pending` and flushes the FIFO on the same edge, so `fifo_count`=0 next cycle. A byte offered in the same cycle is not accepted. A transaction already in flight completes normally.
- rw is always 0. Command transactions use rs=0; data writes use rs=1.
- FSM states:
  - IDLE: the next job is chosen in priority order: clear_pending → CLEAR; else FIFO non-empty && need_addr → ADDR; else FIFO non-empty → DATA; else stay.
  - CLEAR/ADDR/DATA (ISSUE): drive `lcd_enable`=1 and the bus word, held stable until `busy`=1 is sampled. Then go to WAIT_DONE with `lcd_enable`=0 and `lcd_bus`=0.
  - WAIT_DONE: wait for `busy`=0, then go to IDLE.
- Bus words:
  - CLEAR: 10'h001. On completion: `clear_pending`=0, line=0, col=0, `need_addr`=1.
  - ADDR: {2'b00, 1'b1, line ? 7'h40+col : 7'h00+col}. On completion: `need_addr`=0.
  - DATA: {2'b10, FIFO head}. The FIFO is popped on the edge where `busy`=1 is first sampled. If col == COLS-1: col=0, line toggles, `need_addr`=1. Otherwise col+1.
- Wrap: after line 1, col COLS-1, the cursor returns to line 0 col 0 without clearing. Old text is overwritten.
- Simultaneous push and pop: `fifo_count` is unchanged. Push while full is impossible because `char_ready`=0.
- `busy` high while the FSM sits in IDLE (controller still initialising): no `lcd_enable` is driven. IDLE only leaves when `busy`=0.
- Async reset mid-transaction: all state returns to the reset values immediately, and `lcd_enable` drops asynchronously.

## Timing

- Push at edge N → `fifo_count` updates at N; FIFO visible to the FSM from cycle N+1.
- IDLE with a job and `busy`=0 at edge M → `lcd_enable`=1 with a valid bus from M (registered), one cycle of latency.
- The controller raises `busy` one cycle after sampling `lcd_enable`. The writer drops `lcd_enable` on the edge it sees `busy`=1, so at most 2 consecutive cycles of enable per transaction.
- Minimum gap: one IDLE cycle after `busy` falls before the next `lcd_enable`.
- Throughput is bounded by the controller: about 50 µs per transaction. The first character after reset or clear costs 2 transactions (ADDR+DATA); every character at col 0 costs 2.

## Test plan

- Reset idle: hold `reset_n`=0, then release with `busy`=1 for 100 cycles → `lcd_enable`=0, `lcd_bus`=0, `char_ready`=1, `fifo_count`=0 throughout.
- Single char: `busy`=0, push 8'h41 → bus sequence 10'h080 then 10'h241. Each transaction holds `lcd_enable` until `busy` rises, and `fifo_count` returns to 0.
- Line wrap (COLS=16): push 17 bytes 8'h30..8'h40 → 10'h080, 16 data words, then 10'h0C0, then 10'h240. After 32 further bytes, 10'h080 reappears.
- FIFO full: controller model holds `busy`=1, push 16 bytes → `fifo_count`=16 and `char_ready`=0. The 17th `char_valid` is not accepted, and no byte is lost once `busy` falls.
- Clear mid-stream: 5 bytes queued, one DATA transaction in flight, pulse `clear_req` together with `char_valid` → the in-flight transaction completes, FIFO flushed, offered byte rejected, next word 10'h001, then a new char produces 10'h080 first.
- Async reset during ISSUE: assert `reset_n`=0 while `lcd_enable`=1 → `lcd_enable`=0 before the next edge, and all outputs take reset values.
